// File: rtl/cpu_bus_target.sv
// Target end of the multiplexed CPU AD bus: decodes the address/attribute cycle,
// captures write data, runs a req/ack handshake on the local port and returns rdy.
module cpu_bus_target #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_0000,
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_adrcy_i,
   input  logic [31:0] bus_ad_i,
   input  logic        bus_tm1n_i,
   input  logic        bus_tm0n_i,
   output logic [31:0] bus_ad_o,
   output logic        bus_ad_oe_o,
   output logic        bus_rdy_o,
   output logic        bus_err_o,
   output logic        loc_req_o,
   output logic        loc_we_o,
   output logic [29:0] loc_addr_o,
   output logic [3:0]  loc_be_o,
   output logic [31:0] loc_wdata_o,
   input  logic [31:0] loc_rdata_i,
   input  logic        loc_ack_i,
   output logic        proto_err_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, DATA, WAIT, DONE, ERR} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          rd_q, rd_d;
   logic          we_q, we_d;
   logic [29:0]   addr_q, addr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          req_q, req_d;
   logic          rdy_q, rdy_d;
   logic          err_q, err_d;
   logic          oe_q, oe_d;
   logic [31:0]   ado_q, ado_d;
   logic          proto_q, proto_d;

   logic          dec_legal, dec_rd, sel;
   logic [3:0]    dec_be;

   // Attribute decode of {tm1n,tm0n,ad[1:0]} and address select
   always_comb begin
      dec_legal = 1'b1;
      dec_rd    = 1'b0;
      dec_be    = 4'b0000;
      unique case ({bus_tm1n_i, bus_tm0n_i, bus_ad_i[1:0]})
         4'b1100: begin dec_rd = 1'b1; dec_be = 4'b1111; end
         4'b0000: dec_be = 4'b0001;
         4'b0001: dec_be = 4'b0010;
         4'b0010: dec_be = 4'b0100;
         4'b0011: dec_be = 4'b1000;
         4'b0100: dec_be = 4'b1111;
         4'b0101: dec_be = 4'b0011;
         4'b0111: dec_be = 4'b1100;
         default: dec_legal = 1'b0;
      endcase
      sel = (({bus_ad_i[31:2], 2'b00} & ADDR_MASK) == BASE_ADDR);
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rd_d    = rd_q;
      we_d    = we_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      req_d   = 1'b0;
      rdy_d   = 1'b0;
      err_d   = 1'b0;
      oe_d    = 1'b0;
      ado_d   = 32'h0;
      // any address cycle while a transfer is in flight is a protocol violation
      proto_d = proto_q | (bus_adrcy_i && (state_q != IDLE));
      case (state_q)
         IDLE: begin
            if (bus_adrcy_i && sel) begin
               addr_d = bus_ad_i[31:2];
               be_d   = dec_be;
               rd_d   = dec_legal & dec_rd;
               we_d   = dec_legal & ~dec_rd;
               if (!dec_legal) begin
                  state_d = ERR;
                  rdy_d   = 1'b1;
                  err_d   = 1'b1;
               end else if (dec_rd) begin
                  state_d = WAIT;
                  req_d   = 1'b1;
                  timer_d = '0;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            wdata_d = bus_ad_i;
            state_d = WAIT;
            req_d   = 1'b1;
            timer_d = '0;
         end
         WAIT: begin
            // ack has priority over a timeout expiring in the same cycle
            if (loc_ack_i) begin
               state_d = DONE;
               rdy_d   = 1'b1;
               oe_d    = rd_q;
               ado_d   = rd_q ? loc_rdata_i : 32'h0;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d = ERR;
               rdy_d   = 1'b1;
               err_d   = 1'b1;
               oe_d    = rd_q;
               ado_d   = rd_q ? ERR_RDATA : 32'h0;
            end else begin
               timer_d = timer_q + 1'b1;
               req_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         rd_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         req_q   <= 1'b0;
         rdy_q   <= 1'b0;
         err_q   <= 1'b0;
         oe_q    <= 1'b0;
         ado_q   <= '0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         req_q   <= req_d;
         rdy_q   <= rdy_d;
         err_q   <= err_d;
         oe_q    <= oe_d;
         ado_q   <= ado_d;
         proto_q <= proto_d;
      end
   end

   assign bus_ad_o    = ado_q;
   assign bus_ad_oe_o = oe_q;
   assign bus_rdy_o   = rdy_q;
   assign bus_err_o   = err_q;
   assign loc_req_o   = req_q;
   assign loc_we_o    = we_q;
   assign loc_addr_o  = addr_q;
   assign loc_be_o    = be_q;
   assign loc_wdata_o = wdata_q;
   assign proto_err_o = proto_q;

endmodule

// File: tb/tb_cpu_bus_target.sv
// Randomized bench for cpu_bus_target against a transaction-level model.
module tb_cpu_bus_target;
   localparam int TO = 16;

   logic        clk = 1'b0, rst = 1'b1;
   logic        adrcy = 1'b0, tm1n = 1'b1, tm0n = 1'b1, ack = 1'b0;
   logic [31:0] ad = '0, rdata = '0;
   logic [31:0] ad_o, wdata_o;
   logic        oe, rdy, err, req, we, proto;
   logic [29:0] addr_o;
   logic [3:0]  be_o;
   int          checks = 0, failures = 0;
   logic        exp_proto = 1'b0;

   cpu_bus_target dut (
      .clk(clk), .rst(rst), .bus_adrcy_i(adrcy), .bus_ad_i(ad),
      .bus_tm1n_i(tm1n), .bus_tm0n_i(tm0n), .bus_ad_o(ad_o), .bus_ad_oe_o(oe),
      .bus_rdy_o(rdy), .bus_err_o(err), .loc_req_o(req), .loc_we_o(we),
      .loc_addr_o(addr_o), .loc_be_o(be_o), .loc_wdata_o(wdata_o),
      .loc_rdata_i(rdata), .loc_ack_i(ack), .proto_err_o(proto)
   );

   always #5 clk = ~clk;

   // Transaction model: what a given address/attribute cycle should mean
   function automatic void model(input logic [31:0] addr, input logic [1:0] tm, input logic [1:0] a,
                                 output bit sel, output bit legal, output bit rd, output logic [3:0] be);
      sel = (addr[31:16] == 16'h0);
      legal = 1; rd = 0; be = 4'hF;
      if (tm == 2'b11 && a == 2'b00) rd = 1;
      else if (tm == 2'b00) be = 4'b0001 << a;
      else if (tm == 2'b01 && a != 2'b10) be = (a == 2'd0) ? 4'hF : (a == 2'd1) ? 4'h3 : 4'hC;
      else begin legal = 0; be = 4'h0; end
   endfunction

   // One full transfer: address cycle, optional data cycle, ack after dly WAIT cycles
   task automatic run_txn(input logic [31:0] addr, input logic [1:0] tm, input logic [1:0] a,
                          input logic [31:0] wd, input int dly, input logic [31:0] rdat);
      bit sel, legal, rd, first;
      logic [3:0] ebe, gbe;
      logic [29:0] gaddr;
      logic [31:0] gwd, gado;
      logic gwe, gerr, goe;
      int rdy_cyc, req_cnt, oe_bad, exp_rdy, exp_req, ws;
      bit exp_err;
      model(addr, tm, a, sel, legal, rd, ebe);
      @(negedge clk);
      adrcy = 1; ad = {addr[31:2], a}; {tm1n, tm0n} = tm;
      rdy_cyc = -1; req_cnt = 0; oe_bad = 0; first = 1;
      gbe = 'x; gaddr = 'x; gwd = 'x; gwe = 'x; gerr = 'x; goe = 'x; gado = 'x;
      for (int c = 1; c <= TO + 6 && rdy_cyc < 0; c++) begin
         @(negedge clk);
         adrcy = 0; ack = 0;
         ad = (c == 1) ? wd : $urandom;
         if (req) begin
            if (first) begin first = 0; gaddr = addr_o; gbe = be_o; gwe = we; gwd = wdata_o; end
            if (req_cnt == dly) begin ack = 1; rdata = rdat; end
            req_cnt++;
         end
         if (rdy) begin rdy_cyc = c; gerr = err; goe = oe; gado = ad_o; end
         else if (oe) oe_bad++;
      end
      ack = 0;
      exp_err = 0;
      if (!sel) begin exp_rdy = -1; exp_req = 0; end
      else if (!legal) begin exp_rdy = 1; exp_req = 0; exp_err = 1; end
      else begin
         ws = rd ? 1 : 2;
         if (dly < TO) begin exp_rdy = ws + dly + 1; exp_req = dly + 1; end
         else begin exp_rdy = ws + TO; exp_req = TO; exp_err = 1; end
      end
      checks++; if (rdy_cyc != exp_rdy) begin failures++; $display("FAIL rdy_cycle addr=%h tm=%b a=%b got=%0d exp=%0d", addr, tm, a, rdy_cyc, exp_rdy); end
      checks++; if (req_cnt != exp_req) begin failures++; $display("FAIL req_cycles got=%0d exp=%0d", req_cnt, exp_req); end
      checks++; if (oe_bad != 0) begin failures++; $display("FAIL oe_outside_rdy got=%0d exp=0", oe_bad); end
      checks++; if (proto !== exp_proto) begin failures++; $display("FAIL proto_err got=%b exp=%b", proto, exp_proto); end
      if (exp_rdy >= 0) begin
         checks++; if (gerr !== exp_err) begin failures++; $display("FAIL bus_err got=%b exp=%b", gerr, exp_err); end
         checks++; if (goe !== rd) begin failures++; $display("FAIL bus_oe got=%b exp=%b", goe, rd); end
         if (rd) begin
            checks++; if (gado !== (exp_err ? 32'hDEAD_BEEF : rdat)) begin failures++; $display("FAIL rd_data got=%h exp=%h", gado, exp_err ? 32'hDEAD_BEEF : rdat); end
         end
      end
      if (exp_req > 0) begin
         checks++; if (gaddr !== addr[31:2]) begin failures++; $display("FAIL loc_addr got=%h exp=%h", gaddr, addr[31:2]); end
         checks++; if (gbe !== ebe) begin failures++; $display("FAIL loc_be got=%b exp=%b", gbe, ebe); end
         checks++; if (gwe !== !rd) begin failures++; $display("FAIL loc_we got=%b exp=%b", gwe, !rd); end
         if (!rd) begin
            checks++; if (gwd !== wd) begin failures++; $display("FAIL loc_wdata got=%h exp=%h", gwd, wd); end
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({ad_o, oe, rdy, err, req, we, addr_o, be_o, wdata_o, proto} !== '0) begin
         failures++; $display("FAIL reset_outputs got=%h exp=0", {ad_o, oe, rdy, err, req, we, addr_o, be_o, wdata_o, proto});
      end
      rst = 0;
   endtask

   task automatic test_read();
      run_txn(32'h0000_1234, 2'b11, 2'b00, 32'h0, 0, 32'hCAFE_F00D);
   endtask

   task automatic test_write_byte();
      run_txn(32'h0000_0040, 2'b00, 2'b10, 32'h00AB_0000, 0, 32'h0);
      for (int i = 0; i < 4; i++) run_txn(32'h0000_0100 + 32'(i * 4), 2'b00, 2'(i), $urandom, 1, 32'h0);
   endtask

   task automatic test_halfword();
      run_txn(32'h0000_0200, 2'b01, 2'b01, 32'h0000_5566, 0, 32'h0);
      run_txn(32'h0000_0204, 2'b01, 2'b11, 32'h7788_0000, 2, 32'h0);
      run_txn(32'h0000_0208, 2'b01, 2'b10, 32'h1111_1111, 0, 32'h0);
      run_txn(32'h0000_020C, 2'b01, 2'b00, 32'h1234_5678, 3, 32'h0);
   endtask

   task automatic test_illegal();
      run_txn(32'h0000_0300, 2'b10, 2'b00, 32'h0, 0, 32'h0);
      run_txn(32'h0000_0304, 2'b11, 2'b01, 32'h0, 0, 32'h0);
   endtask

   task automatic test_timeout();
      run_txn(32'h0000_0400, 2'b11, 2'b00, 32'h0, TO, 32'h1);
      run_txn(32'h0000_0404, 2'b00, 2'b11, 32'h9900_0000, 99, 32'h0);
      run_txn(32'h0000_0408, 2'b11, 2'b00, 32'h0, TO - 1, 32'hA5A5_5A5A);
   endtask

   task automatic test_unselected();
      run_txn(32'h0001_0000, 2'b11, 2'b00, 32'h0, 0, 32'h0);
      run_txn(32'hFFFF_0010, 2'b00, 2'b00, 32'h0, 0, 32'h0);
   endtask

   task automatic test_back_to_back();
      run_txn(32'h0000_0500, 2'b11, 2'b00, 32'h0, 0, 32'h0102_0304);
      run_txn(32'h0000_0504, 2'b01, 2'b00, 32'hFEED_FACE, 0, 32'h0);
      run_txn(32'h0000_0508, 2'b11, 2'b00, 32'h0, 0, 32'h0506_0708);
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] addr;
         addr = ($urandom_range(0, 3) == 0) ? $urandom : {16'h0, 16'($urandom)};
         run_txn(addr, 2'($urandom), 2'($urandom), $urandom, $urandom_range(0, TO + 3), $urandom);
      end
   endtask

   task automatic test_proto_err();
      @(negedge clk);
      adrcy = 1; ad = 32'h0000_0600; {tm1n, tm0n} = 2'b11;
      @(negedge clk); adrcy = 0;
      @(negedge clk); adrcy = 1; ad = 32'h0000_0700;
      @(negedge clk); adrcy = 0;
      checks++; if (proto !== 1'b1) begin failures++; $display("FAIL proto_set got=%b exp=1", proto); end
      checks++; if (req !== 1'b1) begin failures++; $display("FAIL req_kept_after_stray_adrcy got=%b exp=1", req); end
      ack = 1; rdata = 32'h0BAD_C0DE;
      @(negedge clk); ack = 0;
      checks++; if ({rdy, err, oe, ad_o} !== {3'b101, 32'h0BAD_C0DE}) begin failures++; $display("FAIL stray_adrcy_read got=%b%b%b %h exp=101 0badc0de", rdy, err, oe, ad_o); end
      exp_proto = 1;
      run_txn(32'h0000_0610, 2'b00, 2'b01, 32'h0000_4400, 0, 32'h0);
   endtask

   task automatic test_reset_mid();
      int n;
      @(negedge clk);
      adrcy = 1; ad = 32'h0000_0800; {tm1n, tm0n} = 2'b11;
      @(negedge clk); adrcy = 0;
      n = 0;
      while (!req && n < 10) begin @(negedge clk); n++; end
      @(negedge clk);
      rst = 1;
      #1;
      checks++; if ({req, rdy, oe, proto} !== 4'b0) begin failures++; $display("FAIL reset_mid req/rdy/oe/proto got=%b exp=0000", {req, rdy, oe, proto}); end
      exp_proto = 0;
      @(negedge clk); rst = 0;
      run_txn(32'h0000_0900, 2'b11, 2'b00, 32'h0, 1, 32'h7654_3210);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write_byte();
      test_halfword();
      test_illegal();
      test_timeout();
      test_unselected();
      test_back_to_back();
      test_random();
      test_proto_err();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
